// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bus of the scratch RAM arbiter.
// The slave modport is the arbiter's view; the master is the requesters plus the RAM.
interface ram_arbiter_if #(
  parameter int unsigned ABITS = 5,
  parameter int unsigned DBITS = 9
);
  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [ABITS-1:0] addr0;
  logic [ABITS-1:0] addr1;
  logic [DBITS-1:0] wdata0;
  logic [DBITS-1:0] wdata1;
  logic             gnt0;
  logic             gnt1;
  logic [DBITS-1:0] rdata0;
  logic [DBITS-1:0] rdata1;
  logic             rvalid0;
  logic             rvalid1;
  logic             clr_req;
  logic             clr_busy;
  logic             ram_wr;
  logic [ABITS-1:0] ram_addr;
  logic [DBITS-1:0] ram_din;
  logic [DBITS-1:0] ram_dout;
  logic             ram_res;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, ram_dout,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, clr_busy,
           ram_wr, ram_addr, ram_din, ram_res
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, ram_dout,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, clr_busy,
           ram_wr, ram_addr, ram_din, ram_res
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the shared single-port 32x9 scratch RAM, with clear sequencing.
// Define RAM_ARB_STATS_EN to add saturating per-port grant counters gcnt0/gcnt1.
module ram_arbiter #(
  parameter int unsigned ABITS = 5,
  parameter int unsigned DBITS = 9
) (
  input  logic             clk,
  input  logic             res_n,
  ram_arbiter_if.slave     bus
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [7:0]       gcnt0,
  output logic [7:0]       gcnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StClr1, StClr2} state_e;

  state_e           state_q;
  logic             rr_last_q;
  logic             cmd_valid_q;
  logic             cmd_port_q;
  logic             cmd_we_q;
  logic [ABITS-1:0] cmd_addr_q;
  logic [DBITS-1:0] cmd_wdata_q;
  logic [DBITS-1:0] rdata0_q;
  logic [DBITS-1:0] rdata1_q;
  logic             rvalid0_q;
  logic             rvalid1_q;

  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             win_port;
  logic             ram_wr;
  logic             ram_res;
  logic             clr_busy;
  logic [ABITS-1:0] ram_addr;
  logic [DBITS-1:0] ram_din;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (res_n && (state_q == StIdle) && !bus.clr_req) begin
      gnt0 = bus.req0 && (!bus.req1 || rr_last_q);
      gnt1 = bus.req1 && (!bus.req0 || !rr_last_q);
    end
  end

  assign accept   = gnt0 | gnt1;
  assign win_port = gnt1;

  // ram_res alone leaves location 2 intact, so CLR2 writes it explicitly.
  always_comb begin
    ram_wr   = 1'b0;
    ram_res  = 1'b0;
    clr_busy = 1'b0;
    ram_addr = cmd_addr_q;
    ram_din  = cmd_wdata_q;
    if (!res_n) begin
      ram_res  = 1'b1;
      clr_busy = 1'b1;
    end else begin
      case (state_q)
        StIdle: ram_wr = cmd_valid_q & cmd_we_q;
        StClr1: begin
          ram_res  = 1'b1;
          clr_busy = 1'b1;
        end
        StClr2: begin
          ram_wr   = 1'b1;
          ram_addr = ABITS'(2);
          ram_din  = '0;
          clr_busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= StClr2;
      rr_last_q   <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      rvalid0_q <= cmd_valid_q & ~cmd_we_q & ~cmd_port_q;
      rvalid1_q <= cmd_valid_q & ~cmd_we_q & cmd_port_q;
      if (cmd_valid_q && !cmd_we_q) begin
        if (cmd_port_q) rdata1_q <= bus.ram_dout;
        else            rdata0_q <= bus.ram_dout;
      end

      cmd_valid_q <= accept;
      if (accept) begin
        cmd_port_q  <= win_port;
        cmd_we_q    <= win_port ? bus.we1    : bus.we0;
        cmd_addr_q  <= win_port ? bus.addr1  : bus.addr0;
        cmd_wdata_q <= win_port ? bus.wdata1 : bus.wdata0;
        rr_last_q   <= win_port;
      end

      // A held clr_req repeats the clear without passing through idle.
      case (state_q)
        StIdle:  if (bus.clr_req) state_q <= StClr1;
        StClr1:  state_q <= StClr2;
        StClr2:  state_q <= bus.clr_req ? StClr1 : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [7:0] gcnt0_q;
  logic [7:0] gcnt1_q;

  always_ff @(posedge clk) begin
    if (!res_n || (state_q == StClr1)) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt0 && (gcnt0_q != 8'hFF)) gcnt0_q <= gcnt0_q + 8'd1;
      if (gnt1 && (gcnt1_q != 8'hFF)) gcnt1_q <= gcnt1_q + 8'd1;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`endif

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.clr_busy = clr_busy;
  assign bus.ram_wr   = ram_wr;
  assign bus.ram_res  = ram_res;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_din  = ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: reads are predicted at grant time and checked on rvalid.
// Builds with or without RAM_ARB_STATS_EN.
module tb_ram_arbiter;
  localparam int unsigned ABITS = 5;
  localparam int unsigned DBITS = 9;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

`ifdef RAM_ARB_STATS_EN
  logic [7:0] gcnt0;
  logic [7:0] gcnt1;
`endif

  ram_arbiter #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .gcnt0 (gcnt0),
    .gcnt1 (gcnt1)
`endif
  );

  // RAM behaviour: clear strobe wipes everything except location 2.
  logic [DBITS-1:0] ram [32];
  assign bus.ram_dout = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_res) begin
      for (int i = 0; i < 32; i++) if (i != 2) ram[i] <= '0;
    end else if (bus.ram_wr) begin
      ram[bus.ram_addr] <= bus.ram_din;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference contents and per-port expected read data.
  logic [DBITS-1:0] exp_mem [32];
  logic [DBITS-1:0] q0 [$];
  logic [DBITS-1:0] q1 [$];

  always @(negedge clk) begin
    if (!res_n) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    end else begin
      if (bus.rvalid0) begin
        if (q0.size() == 0) chk("rvalid0_pending", 32'(q0.size()), 1);
        else chk("rdata0", 32'(bus.rdata0), 32'(q0.pop_front()));
      end
      if (bus.rvalid1) begin
        if (q1.size() == 0) chk("rvalid1_pending", 32'(q1.size()), 1);
        else chk("rdata1", 32'(bus.rdata1), 32'(q1.pop_front()));
      end
      if (bus.req0 && bus.gnt0) begin
        if (bus.we0) exp_mem[bus.addr0] = bus.wdata0;
        else q0.push_back(exp_mem[bus.addr0]);
      end
      if (bus.req1 && bus.gnt1) begin
        if (bus.we1) exp_mem[bus.addr1] = bus.wdata1;
        else q1.push_back(exp_mem[bus.addr1]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
  endtask

  task automatic access(input bit p, input logic we, input logic [4:0] a, input logic [8:0] d);
    bit got = 1'b0;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? bus.gnt1 : bus.gnt0;
      step();
    end
    if (!got) chk("grant_timeout", 32'(got), 1);
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.clr_req = 1'b0;
    res_n = 1'b0;

    // Reset for 3 cycles with both ports requesting; no grants allowed.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ram_res", 32'(bus.ram_res), 1);
      chk("rst_clr_busy", 32'(bus.clr_busy), 1);
      chk("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
      chk("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 0);
      if (i < 2) step();
    end
    step();
    res_n = 1'b1;
    @(negedge clk);
    chk("clr2_ram_wr", 32'(bus.ram_wr), 1);
    chk("clr2_ram_addr", 32'(bus.ram_addr), 2);
    chk("clr2_ram_din", 32'(bus.ram_din), 0);
    chk("clr2_clr_busy", 32'(bus.clr_busy), 1);
    chk("clr2_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    chk("idle_clr_busy", 32'(bus.clr_busy), 0);
    chk("idle_ram_wr", 32'(bus.ram_wr), 0);
    chk("idle_ram_res", 32'(bus.ram_res), 0);
    chk("rdata_reset", 32'({bus.rdata1, bus.rdata0}), 0);

    // Port 0 writes addr 5, port 1 reads it back the next cycle.
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wdata0 = 9'h1A5;
    @(negedge clk);
    chk("wr_gnt0", 32'(bus.gnt0), 1);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd5;
    @(negedge clk);
    chk("rd_gnt1", 32'(bus.gnt1), 1);
    chk("wr_exec_ram_wr", 32'(bus.ram_wr), 1);
    chk("wr_exec_ram_addr", 32'(bus.ram_addr), 5);
    chk("wr_exec_ram_din", 32'(bus.ram_din), 32'h1A5);
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("rd_exec_ram_wr", 32'(bus.ram_wr), 0);
    chk("rd_exec_ram_addr", 32'(bus.ram_addr), 5);
    chk("rvalid1_early", 32'(bus.rvalid1), 0);
    step();
    @(negedge clk);
    chk("rvalid1_e2", 32'(bus.rvalid1), 1);
    chk("rdata1_e2", 32'(bus.rdata1), 32'h1A5);
    step();
    @(negedge clk);
    chk("rvalid1_pulse", 32'(bus.rvalid1), 0);
    chk("rdata1_hold", 32'(bus.rdata1), 32'h1A5);

    // Both ports reading continuously: grants alternate, port 0 first.
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
      chk("rr_gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
      step();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // clr_req held high: CLR1/CLR2 repeat back-to-back.
    repeat (3) step();
    bus.req0 = 1'b1; bus.addr0 = 5'd1;
    bus.clr_req = 1'b1;
    clear_model();
    @(negedge clk);
    chk("clrh_gnt0_blocked", 32'(bus.gnt0), 0);
    chk("clrh_busy_idle", 32'(bus.clr_busy), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clrh_ram_res", 32'(bus.ram_res), 32'(i % 2 == 0));
      chk("clrh_ram_wr", 32'(bus.ram_wr), 32'(i % 2 == 1));
      chk("clrh_busy", 32'(bus.clr_busy), 1);
      chk("clrh_gnt0", 32'(bus.gnt0), 0);
      step();
      if (i == 2) bus.clr_req = 1'b0;
    end
    @(negedge clk);
    chk("clrh_gnt0_after", 32'(bus.gnt0), 1);
    step();
    bus.req0 = 1'b0;

    // Fill with 1FF, then clear while both ports request.
    repeat (3) step();
    for (int a = 0; a < 32; a++) access(a[0], 1'b1, 5'(a), 9'h1FF);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd3;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd2;
    bus.clr_req = 1'b1;
    clear_model();
    @(negedge clk);
    chk("clr_gnt_blocked", 32'({bus.gnt1, bus.gnt0}), 0);
    chk("clr_inflight_wr", 32'(bus.ram_wr), 1);
    chk("clr_inflight_addr", 32'(bus.ram_addr), 31);
    step();
    bus.clr_req = 1'b0;
    @(negedge clk);
    chk("clr1_ram_res", 32'(bus.ram_res), 1);
    chk("clr1_ram_wr", 32'(bus.ram_wr), 0);
    chk("clr1_busy", 32'(bus.clr_busy), 1);
    chk("clr1_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
    step();
    @(negedge clk);
    chk("clr2b_ram_wr", 32'(bus.ram_wr), 1);
    chk("clr2b_ram_addr", 32'(bus.ram_addr), 2);
    chk("clr2b_ram_din", 32'(bus.ram_din), 0);
    chk("clr2b_ram_res", 32'(bus.ram_res), 0);
    chk("clr2b_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
    step();
    step();
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int a = 0; a < 32; a++) access(a[0], 1'b0, 5'(a), 9'h000);

    // Read granted, then reset: nothing from it may surface.
    repeat (3) step();
    access(1'b0, 1'b0, 5'd9, 9'h000);
    res_n = 1'b0;
    @(negedge clk);
    chk("rstmid_rd_ram_wr", 32'(bus.ram_wr), 0);
    chk("rstmid_rd_rvalid0", 32'(bus.rvalid0), 0);
    step();
    @(negedge clk);
    chk("rstmid_rd_rvalid0_b", 32'(bus.rvalid0), 0);
    step();
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_rd_rvalid0_c", 32'(bus.rvalid0), 0);
      step();
    end

    // Write granted, then reset: the dropped write must not reach the RAM.
    access(1'b0, 1'b1, 5'd9, 9'h0F0);
    res_n = 1'b0;
    @(negedge clk);
    chk("rstmid_wr_ram_wr", 32'(bus.ram_wr), 0);
    step();
    res_n = 1'b1;
    step();
    step();
    access(1'b0, 1'b0, 5'd9, 9'h000);

`ifdef RAM_ARB_STATS_EN
    // 300 back-to-back port 0 grants saturate gcnt0; a clear zeroes both.
    repeat (3) step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd0;
    repeat (300) step();
    bus.req0 = 1'b0;
    step();
    @(negedge clk);
    chk("gcnt0_sat", 32'(gcnt0), 255);
    chk("gcnt1_zero", 32'(gcnt1), 0);
    step();
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    step();
    @(negedge clk);
    chk("gcnt0_clr", 32'(gcnt0), 0);
    chk("gcnt1_clr", 32'(gcnt1), 0);
`endif

    repeat (4) step();
    chk("sb_q0_drained", 32'(q0.size()), 0);
    chk("sb_q1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
